apb_master_seq: RTL and testbench
=================================

# apb_master_seq

APB initiator sequencer driving the same APB bus signal set as the peripheral-side interface block (Pselx, Penable, Pwrite, Paddr, Pwdata out; Prdata in). It accepts single read/write commands on a valid/ready port, decodes the address to one of three slave selects, and runs the two-phase SETUP/ACCESS sequence. It returns one registered response per accepted command, including error responses for unmapped addresses. It is the bus-master end used by the bridge datapath and by standalone APB test harnesses.

## Interface
Parameters:
- None; bus widths are fixed at 32 bits and the decode map is fixed.

Ports:
- Hclk  in  1  clock; all state changes on rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  target address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse, one per accepted command.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = address decode miss; no APB transfer was issued.
- Pselx  out  3  one-hot slave select.
- Penable  out  1  ACCESS phase indicator.
- Pwrite  out  1  transfer direction.
- Paddr  out  32  transfer address.
- Pwdata  out  32  transfer write data.
- Prdata  in  32  slave read data; valid during ACCESS.

## Operation
- Decode on cmd_addr[31:26]:
  - 0x8000_0000–0x83FF_FFFF -> Pselx 3'b001
  - 0x8400_0000–0x87FF_FFFF -> 3'b010
  - 0x8800_0000–0x8BFF_FFFF -> 3'b100
  - any other address is a miss.
- FSM states are IDLE, SETUP, ACCESS, ERR.
- IDLE: cmd_ready=1.
  - Accept with hit: latch write/addr/wdata/select into Pwrite/Paddr/Pwdata/select registers; go to SETUP.
  - Accept with miss: go to ERR.
  - No command: stay in IDLE.
- SETUP: Pselx=latched select, Penable=0, cmd_ready=0. Always go to ACCESS.
- ACCESS: Pselx held, Penable=1, cmd_ready=1.
  - At the edge ending ACCESS: rsp_valid<=1, rsp_err<=0, rsp_rdata<=Prdata for a read, else 0.
  - Same edge, accept with hit: latch the new command; go to SETUP (back-to-back).
  - Same edge, accept with miss: go to ERR.
  - Same edge, no command: go to IDLE.
- ERR: Pselx=0, Penable=0, cmd_ready=0. At the edge ending ERR: rsp_valid<=1, rsp_err<=1, rsp_rdata<=0. Go to IDLE.
- rsp_valid, rsp_rdata and rsp_err are registers.
  - rsp_valid clears the cycle after any pulse unless a new response is written.
  - rsp_rdata and rsp_err hold their value while rsp_valid=0.
- Pwrite, Paddr and Pwdata hold the last transfer's values in IDLE and ERR; they update only on a hit acceptance.
- A miss never changes any P* output.
- Pselx and Penable are 0 in IDLE and ERR.

## Timing
- Reset (asynchronous, immediate): state=IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0; rsp_valid=0, rsp_rdata=0, rsp_err=0.
- cmd_ready is forced 0 while Hreset=1.
- Hit accepted at edge E:
  - SETUP in cycle E+1.
  - ACCESS in cycle E+2; Prdata is sampled at the end of this cycle.
  - rsp_valid high in cycle E+3.
- Miss accepted at edge E: ERR in cycle E+1; rsp_valid with rsp_err=1 in cycle E+2.
- Back-to-back hits give one APB transfer every 2 cycles.
  - The new SETUP directly follows ACCESS; Penable drops to 0 for that cycle; Pselx switches to the new select.
- Miss accepted during ACCESS: the transfer response is in cycle E+1 and the error response in E+2. Responses never collide and always return in command order.
- No backpressure on responses: the consumer must accept rsp_valid every cycle.
- Reset during SETUP or ACCESS aborts the transfer. Pselx and Penable drop asynchronously and no response is issued.
- Prdata is ignored outside ACCESS and for writes.

## Test plan
- Write: cmd 0x8000_0010 / 0xDEADBEEF.
  - Required: SETUP with Pselx=001, Penable=0, Pwrite=1, Paddr=0x8000_0010, Pwdata=0xDEADBEEF.
  - Next cycle: Penable=1.
  - Next cycle: rsp_valid=1, rsp_rdata=0, rsp_err=0.
- Read: cmd 0x8400_0004 with the slave model returning 25 in ACCESS -> Pselx=010, Pwrite=0; response 3 cycles after acceptance with rsp_rdata=0x0000_0019.
- Back-to-back: cmd_valid held through a read to 0x8800_0000 and then a write to 0x8000_0000.
  - Expected Penable sequence 0,1,0,1.
  - Pselx goes 100 then 001 with no IDLE gap.
  - Two rsp_valid pulses 2 cycles apart.
- Miss: cmd 0x9000_0000 in IDLE -> Pselx and Penable stay 0; Paddr unchanged; rsp_valid with rsp_err=1 two cycles after acceptance.
- Miss during ACCESS: the read response is in cycle E+1 with err=0, and the error response in E+2 with err=1.
- Reset asserted mid-ACCESS -> Pselx, Penable and rsp outputs go to 0 immediately; no rsp_valid after release; cmd_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/apb_master_seq.sv
// apb_master_seq: APB initiator that turns single valid/ready commands into SETUP/ACCESS transfers with one registered response each.
module apb_master_seq (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   input  logic [31:0] Prdata
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;
   state_t      state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic        pwrite_q;
   logic [31:0] paddr_q, pwdata_q, rsp_rdata_q;
   logic        rsp_valid_q, rsp_err_q;
   logic        hit, acc, done;
   // Three 64 MiB windows starting at 0x8000_0000; 0x8C.. and above miss.
   assign hit = cmd_addr[31:28] == 4'h8 && cmd_addr[27:26] != 2'b11;
   assign sel_d = 3'b001 << cmd_addr[27:26];
   assign cmd_ready = ~Hreset & (state_q == IDLE | state_q == ACCESS);
   assign acc = cmd_valid & cmd_ready;
   assign done = state_q == ACCESS | state_q == ERR;
   always_comb begin
      state_d = acc ? (hit ? SETUP : ERR) : (state_q == SETUP ? ACCESS : IDLE);
   end
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_q     <= IDLE;
         sel_q       <= 3'b000;
         pwrite_q    <= 1'b0;
         paddr_q     <= 32'h0;
         pwdata_q    <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= done;
         if (acc && hit) begin
            sel_q    <= sel_d;
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
         end
         if (done) begin
            rsp_err_q   <= state_q == ERR;
            rsp_rdata_q <= (state_q == ACCESS && !pwrite_q) ? Prdata : 32'h0;
         end
      end
   end
   assign Pselx     = (state_q == SETUP || state_q == ACCESS) ? sel_q : 3'b000;
   assign Penable   = state_q == ACCESS;
   assign Pwrite    = pwrite_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_seq.sv
// tb_apb_master_seq: directed vector table, hand-written multi-cycle sequences and a randomized cycle-timeline model.
module tb_apb_master_seq;
   localparam int NR = 800;
   logic        Hclk = 1'b0, Hreset = 1'b1, cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0, Prdata = 32'h0;
   logic        cmd_ready, rsp_valid, rsp_err, Penable, Pwrite;
   logic [31:0] rsp_rdata, Paddr, Pwdata;
   logic [2:0]  Pselx;
   int          checks = 0, errors = 0;
   apb_master_seq dut (
      .Hclk(Hclk), .Hreset(Hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
      .Pwdata(Pwdata), .Prdata(Prdata)
   );
   always #5 Hclk = ~Hclk;
   typedef struct {
      logic        wr;
      logic [31:0] addr, wdata, prdata, rdata;
      logic [2:0]  sel;
   } vec_t;
   vec_t        tbl[7];
   logic [31:0] bnd[6];
   logic [31:0] last_addr;
   bit          blocked[NR+4], pen_e[NR+4], rsp_v[NR+4], rsp_rd[NR+4], rsp_er[NR+4];
   bit   [2:0]  psel_e[NR+4];
   logic [31:0] prd_h[NR+4];
   logic        m_pwrite, m_err;
   logic [31:0] m_paddr, m_pwdata, m_rdata;
   logic [2:0]  s;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic step;
      @(posedge Hclk);
      #1;
   endtask
   task automatic smp;
      @(negedge Hclk);
   endtask
   task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      cmd_valid = v;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask
   // Select derived from the address map as plain range arithmetic.
   function automatic logic [2:0] dec(input logic [31:0] a);
      if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
      return 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         32'h0,         3'b001};
      tbl[1] = '{1'b0, 32'h8400_0004, 32'h0,         32'd25,        32'h0000_0019, 3'b010};
      tbl[2] = '{1'b0, 32'h83FF_FFFC, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b001};
      tbl[3] = '{1'b1, 32'h8BFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0,         3'b100};
      tbl[4] = '{1'b1, 32'h9000_0000, 32'h1111,      32'h0,         32'h0,         3'b000};
      tbl[5] = '{1'b0, 32'h8C00_0000, 32'h0,         32'h4444,      32'h0,         3'b000};
      tbl[6] = '{1'b0, 32'h7FFF_FFFF, 32'h0,         32'h5555,      32'h0,         3'b000};
      bnd = '{32'h7FFF_FFFF, 32'h83FF_FFFF, 32'h8BFF_FFFF, 32'h8C00_0000, 32'hFFFF_FFFF, 32'h0};
      last_addr = 32'h0;
      #12;
      chk("rst_psel", Pselx, 0); chk("rst_pen", Penable, 0); chk("rst_pwrite", Pwrite, 0);
      chk("rst_paddr", Paddr, 0); chk("rst_pwdata", Pwdata, 0); chk("rst_rspv", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0); chk("rst_err", rsp_err, 0); chk("rst_ready", cmd_ready, 0);
      step;
      Hreset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step;
         drive(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
         Prdata = tbl[i].prdata;
         smp; chk("idle_ready", cmd_ready, 1);
         step;
         cmd_valid = 1'b0;
         smp;
         if (tbl[i].sel != 3'b000) begin
            chk("setup_psel", Pselx, tbl[i].sel); chk("setup_pen", Penable, 0);
            chk("setup_pwrite", Pwrite, tbl[i].wr); chk("setup_paddr", Paddr, tbl[i].addr);
            chk("setup_pwdata", Pwdata, tbl[i].wdata); chk("setup_ready", cmd_ready, 0);
            last_addr = tbl[i].addr;
            step; smp;
            chk("access_pen", Penable, 1); chk("access_psel", Pselx, tbl[i].sel);
            step; smp;
            chk("rsp_valid", rsp_valid, 1); chk("rsp_err", rsp_err, 0);
            chk("rsp_rdata", rsp_rdata, tbl[i].rdata); chk("post_pen", Penable, 0); chk("post_psel", Pselx, 0);
         end else begin
            chk("miss_psel", Pselx, 0); chk("miss_pen", Penable, 0);
            chk("miss_paddr", Paddr, last_addr); chk("miss_ready", cmd_ready, 0);
            step; smp;
            chk("miss_rspv", rsp_valid, 1); chk("miss_err", rsp_err, 1); chk("miss_rdata", rsp_rdata, 0);
         end
         step; smp;
         chk("rsp_clear", rsp_valid, 0); chk("rsp_hold", rsp_rdata, tbl[i].rdata);
      end
      // Back-to-back read then write with cmd_valid held.
      step; drive(1'b1, 1'b0, 32'h8800_0000, 32'h0); Prdata = 32'h0; smp;
      step; drive(1'b1, 1'b1, 32'h8000_0000, 32'hCAFE_F00D); smp;
      chk("b2b_pen0", Penable, 0); chk("b2b_psel0", Pselx, 3'b100);
      step; Prdata = 32'h1357_2468; smp;
      chk("b2b_pen1", Penable, 1); chk("b2b_psel1", Pselx, 3'b100); chk("b2b_ready", cmd_ready, 1);
      step; cmd_valid = 1'b0; smp;
      chk("b2b_pen2", Penable, 0); chk("b2b_psel2", Pselx, 3'b001); chk("b2b_rspv1", rsp_valid, 1);
      chk("b2b_rdata1", rsp_rdata, 32'h1357_2468); chk("b2b_paddr", Paddr, 32'h8000_0000);
      step; smp;
      chk("b2b_pen3", Penable, 1); chk("b2b_psel3", Pselx, 3'b001); chk("b2b_gap", rsp_valid, 0);
      step; smp;
      chk("b2b_rspv2", rsp_valid, 1); chk("b2b_rdata2", rsp_rdata, 0); chk("b2b_psel4", Pselx, 0);
      step; smp; chk("b2b_clear", rsp_valid, 0);
      // Miss accepted in ACCESS.
      step; drive(1'b1, 1'b0, 32'h8000_0020, 32'h0); smp;
      step; drive(1'b1, 1'b0, 32'hC000_0000, 32'h0); smp; chk("mia_setup_ready", cmd_ready, 0);
      step; Prdata = 32'h55AA_55AA; smp; chk("mia_pen", Penable, 1); chk("mia_ready", cmd_ready, 1);
      step; cmd_valid = 1'b0; smp;
      chk("mia_rspv1", rsp_valid, 1); chk("mia_err1", rsp_err, 0); chk("mia_rdata1", rsp_rdata, 32'h55AA_55AA);
      chk("mia_psel", Pselx, 0); chk("mia_err_ready", cmd_ready, 0); chk("mia_paddr", Paddr, 32'h8000_0020);
      step; smp;
      chk("mia_rspv2", rsp_valid, 1); chk("mia_err2", rsp_err, 1); chk("mia_rdata2", rsp_rdata, 0);
      step; smp; chk("mia_clear", rsp_valid, 0); chk("mia_errhold", rsp_err, 1);
      // Reset in the middle of ACCESS.
      step; drive(1'b1, 1'b1, 32'h8400_0100, 32'h77); smp;
      step; cmd_valid = 1'b0; smp;
      step; smp; chk("rma_pen", Penable, 1); chk("rma_psel", Pselx, 3'b010);
      #1 Hreset = 1'b1;
      #1;
      chk("rma_psel0", Pselx, 0); chk("rma_pen0", Penable, 0); chk("rma_rspv", rsp_valid, 0);
      chk("rma_err", rsp_err, 0); chk("rma_rdata", rsp_rdata, 0); chk("rma_ready", cmd_ready, 0);
      chk("rma_paddr", Paddr, 0);
      step; Hreset = 1'b0; smp;
      chk("rma_ready_rel", cmd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         chk("rma_no_rsp", rsp_valid, 0);
         step; smp;
      end
      // Randomized traffic against a per-cycle timeline of expected bus activity.
      m_pwrite = 1'b0; m_paddr = 32'h0; m_pwdata = 32'h0; m_rdata = 32'h0; m_err = 1'b0;
      for (int c = 0; c < NR; c++) begin
         step;
         cmd_valid = $urandom_range(0, 3) != 0;
         cmd_write = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0, 1, 2: cmd_addr = 32'h8000_0000 + 32'h0400_0000 * $urandom_range(0, 2) + ($urandom & 32'h03FF_FFFF);
            3:       cmd_addr = bnd[$urandom_range(0, 5)];
            default: cmd_addr = $urandom;
         endcase
         cmd_wdata = $urandom;
         Prdata = $urandom;
         prd_h[c] = Prdata;
         smp;
         if (rsp_v[c]) begin
            m_rdata = rsp_rd[c] ? prd_h[c-1] : 32'h0;
            m_err = rsp_er[c];
         end
         chk("r_ready", cmd_ready, !blocked[c]); chk("r_psel", Pselx, psel_e[c]); chk("r_pen", Penable, pen_e[c]);
         chk("r_pwrite", Pwrite, m_pwrite); chk("r_paddr", Paddr, m_paddr); chk("r_pwdata", Pwdata, m_pwdata);
         chk("r_rspv", rsp_valid, rsp_v[c]); chk("r_rdata", rsp_rdata, m_rdata); chk("r_err", rsp_err, m_err);
         if (cmd_valid && !blocked[c]) begin
            s = dec(cmd_addr);
            blocked[c+1] = 1'b1;
            if (s != 3'b000) begin
               psel_e[c+1] = s; psel_e[c+2] = s; pen_e[c+2] = 1'b1;
               rsp_v[c+3] = 1'b1; rsp_rd[c+3] = !cmd_write;
               m_pwrite = cmd_write; m_paddr = cmd_addr; m_pwdata = cmd_wdata;
            end else begin
               rsp_v[c+2] = 1'b1; rsp_er[c+2] = 1'b1;
            end
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
